// File: rtl/hdmi_to_blocks.sv
// Raster-to-block converter: HDMI pixel words are written line by line into
// one of two 8-line stripe buffers while the other buffer is read back as
// 8x8 blocks. The output passes through a 2-entry skid buffer with valid/ready.
module hdmi_to_blocks #(
  parameter int N     = 2,
  parameter int X_RES = 2160,
  parameter int Y_RES = 1200
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   hdmi_v_sync,
  input  logic                   hdmi_h_sync,
  input  logic                   hdmi_data_valid,
  input  logic signed [N-1:0][7:0] hdmi_data_y,
  input  logic signed [N-1:0][7:0] hdmi_data_cr,
  input  logic signed [N-1:0][7:0] hdmi_data_cb,
  input  logic                   blk_ready,
  output logic                   blk_valid,
  output logic signed [N-1:0][7:0] blk_data_y,
  output logic signed [N-1:0][7:0] blk_data_cr,
  output logic signed [N-1:0][7:0] blk_data_cb,
  output logic                   blk_sob,
  output logic                   blk_eob,
  output logic                   blk_sof,
  output logic                   err_overflow
);

  localparam int WPL       = X_RES / N;
  localparam int BUF_DEPTH = X_RES * 8 / N;
  localparam int BPL       = X_RES / 8;
  localparam int WPB       = 8 / N;
  localparam int NSTRIPE   = Y_RES / 8;
  localparam int PW        = 3 * N * 8;
  localparam int AW        = $clog2(2 * BUF_DEPTH);
  localparam int CW        = $clog2(WPL + 1);
  localparam int SW        = $clog2(NSTRIPE + 1);
  localparam int BW        = $clog2(BPL + 1);
  localparam int EW        = $clog2(WPB + 1);

  typedef enum logic {R_IDLE, R_READ} rstate_t;

  // write side
  logic          vs_q, hs_q, vs_rise, hs_rise;
  logic          armed, stripe_open, drop_q, wsel;
  logic [CW-1:0] col, eff_col;
  logic [2:0]    line, eff_line;
  logic [SW-1:0] stripe, eff_stripe;
  logic          wr_event, stripe_start, stripe_end, buf_free, drop_now, wr_en;
  logic [AW-1:0] wr_idx;
  logic [1:0]    buf_full, sof_tag;

  // read side
  rstate_t       rstate;
  logic          rbuf;
  logic [BW-1:0] blk;
  logic [2:0]    bline;
  logic [EW-1:0] belem;
  logic          issue, rd_last, rd_release, credit_ok;
  logic [AW-1:0] rd_idx;
  logic [2:0]    tag_now;
  logic [PW-1:0] mem [0:2*BUF_DEPTH-1];
  logic [PW-1:0] ram_q;
  logic          rd_valid;
  logic [2:0]    rd_tag;

  // output skid buffer
  logic            head_v, spare_v, push, pop;
  logic [PW+2:0]   head, spare, skid_in;
  logic [1:0]      occupancy;

  // Effective write position: sync edges take effect on the word of the same cycle
  always_comb begin
    vs_rise      = hdmi_v_sync & ~vs_q;
    hs_rise      = hdmi_h_sync & ~hs_q;
    eff_col      = (vs_rise | hs_rise) ? '0 : col;
    eff_line     = vs_rise ? '0 : line;
    eff_stripe   = vs_rise ? '0 : stripe;
    wr_event     = hdmi_data_valid & (armed | vs_rise);
    stripe_start = wr_event & (vs_rise | ~stripe_open);
    stripe_end   = wr_event & (eff_line == 3'd7) & (eff_col == CW'(WPL - 1));
    // a buffer released by the reader in this very cycle counts as free
    buf_free     = ~buf_full[wsel] | (rd_release & (rbuf == wsel));
    drop_now     = stripe_start ? ~buf_free : drop_q;
    wr_en        = wr_event & ~drop_now;
    wr_idx       = AW'(wsel ? BUF_DEPTH : 0) + AW'(eff_line) * AW'(WPL) + AW'(eff_col);
  end

  // Raster position, frame arming, overflow flag and write buffer select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q         <= 1'b0;
      hs_q         <= 1'b0;
      armed        <= 1'b0;
      stripe_open  <= 1'b0;
      drop_q       <= 1'b0;
      wsel         <= 1'b0;
      col          <= '0;
      line         <= '0;
      stripe       <= '0;
      err_overflow <= 1'b0;
    end else begin
      vs_q <= hdmi_v_sync;
      hs_q <= hdmi_h_sync;
      if (vs_rise) begin
        armed        <= 1'b1;
        err_overflow <= 1'b0;
        col          <= '0;
        line         <= '0;
        stripe       <= '0;
        stripe_open  <= 1'b0;
        drop_q       <= 1'b0;
      end else if (hs_rise) begin
        col <= '0;
      end
      if (wr_event) begin
        stripe_open <= 1'b1;
        drop_q      <= drop_now;
        if (stripe_start && drop_now) err_overflow <= 1'b1;
        if (eff_col == CW'(WPL - 1)) begin
          col  <= '0;
          line <= eff_line + 3'd1;
        end else begin
          col  <= eff_col + CW'(1);
          line <= eff_line;
        end
        if (stripe_end) begin
          stripe_open <= 1'b0;
          stripe      <= eff_stripe + SW'(1);
          if ((eff_stripe + SW'(1)) == SW'(NSTRIPE)) armed <= 1'b0;
          // a dropped stripe leaves the select on the still-busy buffer
          if (!drop_now) wsel <= ~wsel;
        end
      end
    end
  end

  // Buffer occupancy: filled by the writer, released by the reader
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_full <= '0;
      sof_tag  <= '0;
    end else begin
      if (rd_release) buf_full[rbuf] <= 1'b0;
      if (stripe_end && !drop_now) begin
        buf_full[wsel] <= 1'b1;
        sof_tag[wsel]  <= (eff_stripe == '0);
      end
    end
  end

  // Stripe RAM: raster-order writes, registered block-order reads
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= {hdmi_data_y, hdmi_data_cr, hdmi_data_cb};
    ram_q <= mem[rd_idx];
  end

  // Block-order address generation and issue credit
  always_comb begin
    pop       = head_v & blk_ready;
    push      = rd_valid;
    occupancy = {1'b0, head_v} + {1'b0, spare_v} + {1'b0, rd_valid};
    credit_ok = occupancy <= (2'd1 + {1'b0, pop});
    issue     = (rstate == R_READ) & credit_ok;
    rd_last   = (blk == BW'(BPL - 1)) & (bline == 3'd7) & (belem == EW'(WPB - 1));
    rd_release = issue & rd_last;
    rd_idx    = AW'(rbuf ? BUF_DEPTH : 0) + AW'(blk) * AW'(WPB)
              + AW'(bline) * AW'(WPL) + AW'(belem);
    tag_now[2] = (bline == 3'd0) & (belem == '0);
    tag_now[1] = (bline == 3'd7) & (belem == EW'(WPB - 1));
    tag_now[0] = tag_now[2] & (blk == '0) & sof_tag[rbuf];
    skid_in   = {ram_q, rd_tag};
  end

  // Read FSM: picks a full buffer and walks it block by block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate <= R_IDLE;
      rbuf   <= 1'b0;
      blk    <= '0;
      bline  <= '0;
      belem  <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          blk   <= '0;
          bline <= '0;
          belem <= '0;
          if (buf_full != '0) begin
            rstate <= R_READ;
            rbuf   <= (buf_full == 2'b11) ? ~wsel : buf_full[1];
          end
        end
        R_READ: begin
          if (issue) begin
            if (belem == EW'(WPB - 1)) begin
              belem <= '0;
              if (bline == 3'd7) begin
                bline <= '0;
                if (blk == BW'(BPL - 1)) begin
                  blk <= '0;
                  if (buf_full[~rbuf]) rbuf <= ~rbuf;
                  else rstate <= R_IDLE;
                end else begin
                  blk <= blk + BW'(1);
                end
              end else begin
                bline <= bline + 3'd1;
              end
            end else begin
              belem <= belem + EW'(1);
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // Read-data valid and tags, aligned with the registered RAM output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_tag   <= '0;
    end else begin
      rd_valid <= issue;
      rd_tag   <= tag_now;
    end
  end

  // Two-entry skid buffer; head is the registered output word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_v  <= 1'b0;
      spare_v <= 1'b0;
      head    <= '0;
      spare   <= '0;
    end else if (pop) begin
      if (spare_v) begin
        head <= spare;
        if (push) spare <= skid_in;
        else spare_v <= 1'b0;
      end else if (push) begin
        head <= skid_in;
      end else begin
        head_v <= 1'b0;
      end
    end else if (push) begin
      if (!head_v) begin
        head   <= skid_in;
        head_v <= 1'b1;
      end else begin
        spare   <= skid_in;
        spare_v <= 1'b1;
      end
    end
  end

  assign blk_valid = head_v;
  assign {blk_data_y, blk_data_cr, blk_data_cb, blk_sob, blk_eob, blk_sof} = head;

endmodule

// File: tb/tb_hdmi_to_blocks.sv
// Bench for hdmi_to_blocks: raster stimulus, block-order expectation queue,
// per-cycle output comparison and a few literal anchors.
module tb_hdmi_to_blocks;

  localparam int N     = 2;
  localparam int X_RES = 16;
  localparam int Y_RES = 32;
  localparam int WPL   = X_RES / N;
  localparam int BPL   = X_RES / 8;
  localparam int WPB   = 8 / N;
  localparam int NSTR  = Y_RES / 8;

  typedef struct packed {
    logic [N*8-1:0] y;
    logic [N*8-1:0] cr;
    logic [N*8-1:0] cb;
    logic sob;
    logic eob;
    logic sof;
  } word_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic hdmi_v_sync = 1'b0, hdmi_h_sync = 1'b0, hdmi_data_valid = 1'b0;
  logic signed [N-1:0][7:0] hdmi_data_y = '0, hdmi_data_cr = '0, hdmi_data_cb = '0;
  logic blk_ready = 1'b0;
  logic blk_valid, blk_sob, blk_eob, blk_sof, err_overflow;
  logic signed [N-1:0][7:0] blk_data_y, blk_data_cr, blk_data_cb;

  hdmi_to_blocks #(.N(N), .X_RES(X_RES), .Y_RES(Y_RES)) dut (
    .clk(clk), .rst_n(rst_n),
    .hdmi_v_sync(hdmi_v_sync), .hdmi_h_sync(hdmi_h_sync),
    .hdmi_data_valid(hdmi_data_valid),
    .hdmi_data_y(hdmi_data_y), .hdmi_data_cr(hdmi_data_cr), .hdmi_data_cb(hdmi_data_cb),
    .blk_ready(blk_ready), .blk_valid(blk_valid),
    .blk_data_y(blk_data_y), .blk_data_cr(blk_data_cr), .blk_data_cb(blk_data_cb),
    .blk_sob(blk_sob), .blk_eob(blk_eob), .blk_sof(blk_sof),
    .err_overflow(err_overflow)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  word_t exp_q[$];
  word_t cap[0:255];
  int    acc_cnt = 0, sof_cnt = 0, eob_cnt = 0, eob_at_sof2 = -1, vcount = 0;
  logic  rand_mode = 1'b0, ready_fixed = 1'b1;
  word_t cur, prev_word;
  logic  prev_stall = 1'b0;

  always_comb cur = {blk_data_y, blk_data_cr, blk_data_cb, blk_sob, blk_eob, blk_sof};

  function automatic logic [7:0] pix(int fl, int x, int seed);
    return 8'((fl * 16 + x + seed) % 128);
  endfunction

  // Block-order expectation for one stripe, derived from the pixel rule
  task automatic push_stripe(int s, int seed);
    word_t w;
    for (int b = 0; b < BPL; b++)
      for (int r = 0; r < 8; r++)
        for (int e = 0; e < WPB; e++) begin
          for (int j = 0; j < N; j++) begin
            logic [7:0] yv;
            yv = pix(s * 8 + r, b * 8 + e * N + j, seed);
            w.y[j*8 +: 8]  = yv;
            w.cr[j*8 +: 8] = ~yv;
            w.cb[j*8 +: 8] = yv + 8'd1;
          end
          w.sob = (r == 0) && (e == 0);
          w.eob = (r == 7) && (e == WPB - 1);
          w.sof = w.sob && (b == 0) && (s == 0);
          exp_q.push_back(w);
        end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    hdmi_data_valid = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_line(int fl, int seed, int hblank, bit with_vs);
    if (!with_vs) begin
      hdmi_h_sync = 1'b1;
      cyc();
      hdmi_h_sync = 1'b0;
    end else begin
      hdmi_v_sync = 1'b1;
    end
    for (int c = 0; c < WPL; c++) begin
      for (int j = 0; j < N; j++) begin
        hdmi_data_y[j]  = pix(fl, c * N + j, seed);
        hdmi_data_cr[j] = ~pix(fl, c * N + j, seed);
        hdmi_data_cb[j] = pix(fl, c * N + j, seed) + 8'd1;
      end
      hdmi_data_valid = 1'b1;
      cyc();
      hdmi_v_sync = 1'b0;
    end
    idle(hblank);
  endtask

  task automatic send_stripe(int s, int seed, int hblank, bit with_vs, bit keep);
    if (keep) push_stripe(s, seed);
    for (int r = 0; r < 8; r++) send_line(s * 8 + r, seed, hblank, with_vs && (r == 0));
  endtask

  task automatic vsync_pulse();
    hdmi_v_sync = 1'b1;
    cyc();
    cyc();
    hdmi_v_sync = 1'b0;
    cyc();
  endtask

  task automatic frame(int seed_base, int step, int hblank);
    vsync_pulse();
    for (int s = 0; s < NSTR; s++) send_stripe(s, seed_base + s * step, hblank, 1'b0, 1'b1);
  endtask

  task automatic wait_drain(string name, int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || blk_valid) && k < budget) begin
      cyc();
      k++;
    end
    n_tests++;
    if (k >= budget) begin
      n_fail++;
      $display("FAIL %s: drain timeout, %0d words still expected", name, exp_q.size());
    end
    idle(10);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    exp_q.delete();
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  // Ready generation: fixed level or 50% random
  always @(posedge clk) begin
    #1;
    blk_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
  end

  // Output checker: stability while stalled, and every accepted word vs. the queue
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (blk_valid) vcount++;
      if (prev_stall) begin
        n_tests++;
        if (!blk_valid || cur !== prev_word) begin
          n_fail++;
          $display("FAIL stall_hold: got valid=%b word=%h, required valid=1 word=%h",
                   blk_valid, cur, prev_word);
        end
      end
      if (blk_valid && blk_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL word: got unexpected word %h, required no output", cur);
        end else begin
          word_t e;
          e = exp_q.pop_front();
          if (cur !== e) begin
            n_fail++;
            $display("FAIL word %0d: got %h, required %h", acc_cnt, cur, e);
          end
        end
        if (acc_cnt < 256) cap[acc_cnt] = cur;
        acc_cnt++;
        if (blk_sof) begin
          if (sof_cnt == 1) eob_at_sof2 = eob_cnt;
          sof_cnt++;
        end
        if (blk_eob) eob_cnt++;
      end
      prev_stall = blk_valid && !blk_ready;
      prev_word  = cur;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    repeat (3) cyc();
    chk("rst_valid_in_reset", {63'd0, blk_valid}, 64'd0);
    chk("rst_err_in_reset", {63'd0, err_overflow}, 64'd0);
    rst_n = 1'b1;
    cyc();
    chk("rst_valid", {63'd0, blk_valid}, 64'd0);
    chk("rst_flags", {61'd0, blk_sob, blk_eob, blk_sof}, 64'd0);
    chk("rst_data", {16'd0, blk_data_y, blk_data_cr, blk_data_cb}, 64'd0);
    chk("rst_err", {63'd0, err_overflow}, 64'd0);

    // 1: one frame, always ready
    acc_cnt = 0; sof_cnt = 0; eob_cnt = 0;
    frame(0, 0, 4);
    wait_drain("s1_drain", 1000);
    chk("s1_words", acc_cnt, 256);
    chk("s1_blocks", eob_cnt, 8);
    chk("s1_sof_count", sof_cnt, 1);
    chk("s1_w0_y", cap[0].y, 64'h0100);
    chk("s1_w0_cr", cap[0].cr, 64'hfeff);
    chk("s1_w0_cb", cap[0].cb, 64'h0201);
    chk("s1_w0_flags", {cap[0].sob, cap[0].eob, cap[0].sof}, 64'b101);
    chk("s1_w4_y", cap[4].y, 64'h1110);
    chk("s1_w31_eob", {cap[31].sob, cap[31].eob, cap[31].sof}, 64'b010);
    chk("s1_blk1_w0", {cap[32].y, 1'b0, cap[32].sof}, {16'h0908, 2'b00});
    chk("s1_blk1_w3_y", cap[35].y, 64'h0f0e);
    chk("s1_last_y", {cap[255].y, cap[255].eob}, {16'h7f7e, 1'b1});

    // 2: random ready over three frames
    acc_cnt = 0; sof_cnt = 0;
    rand_mode = 1'b1;
    for (int f = 0; f < 3; f++) frame(0, 0, 24);
    wait_drain("s2_drain", 3000);
    rand_mode = 1'b0;
    chk("s2_words", acc_cnt, 768);
    chk("s2_sof_count", sof_cnt, 3);
    chk("s2_no_overflow", {63'd0, err_overflow}, 64'd0);

    // 3: downstream stalled for three stripes
    acc_cnt = 0;
    ready_fixed = 1'b0;
    vsync_pulse();
    send_stripe(0, 3, 4, 1'b0, 1'b1);
    send_stripe(1, 40, 4, 1'b0, 1'b1);
    chk("s3_err_clear_before_drop", {63'd0, err_overflow}, 64'd0);
    send_stripe(2, 77, 4, 1'b0, 1'b0);
    chk("s3_err_set", {63'd0, err_overflow}, 64'd1);
    chk("s3_valid_held", {63'd0, blk_valid}, 64'd1);
    ready_fixed = 1'b1;
    wait_drain("s3_drain", 1000);
    chk("s3_words", acc_cnt, 128);
    chk("s3_err_sticky", {63'd0, err_overflow}, 64'd1);
    send_stripe(3, 114, 4, 1'b0, 1'b1);
    wait_drain("s3_drain2", 1000);
    chk("s3_words_after", acc_cnt, 192);
    vsync_pulse();
    chk("s3_err_cleared", {63'd0, err_overflow}, 64'd0);

    // 4: h_sync realigns the column mid-line
    acc_cnt = 0;
    vsync_pulse();
    push_stripe(0, 5);
    send_line(0, 5, 4, 1'b0);
    send_line(1, 5, 4, 1'b0);
    hdmi_data_y = {8'h55, 8'h55}; hdmi_data_cr = {8'h55, 8'h55}; hdmi_data_cb = {8'h55, 8'h55};
    hdmi_data_valid = 1'b1;
    repeat (3) cyc();
    idle(2);
    for (int r = 2; r < 8; r++) send_line(r, 5, 4, 1'b0);
    for (int s = 1; s < NSTR; s++) send_stripe(s, 5 + s * 19, 4, 1'b0, 1'b1);
    wait_drain("s4_drain", 1000);
    chk("s4_words", acc_cnt, 256);

    // 5: reset during stripe 1 readout
    vsync_pulse();
    send_stripe(0, 9, 4, 1'b0, 1'b1);
    send_stripe(1, 46, 4, 1'b0, 1'b1);
    idle(15);
    reset_dut();
    chk("s5_valid_after_reset", {63'd0, blk_valid}, 64'd0);
    vcount = 0;
    send_stripe(2, 83, 4, 1'b0, 1'b0);
    send_stripe(3, 120, 4, 1'b0, 1'b0);
    idle(80);
    chk("s5_no_output_unarmed", vcount, 0);
    acc_cnt = 0; sof_cnt = 0;
    frame(13, 29, 4);
    wait_drain("s5_drain", 1000);
    chk("s5_words", acc_cnt, 256);
    chk("s5_sof_count", sof_cnt, 1);

    // 6: back-to-back frames, second v_sync rise carries the first word
    acc_cnt = 0; sof_cnt = 0; eob_cnt = 0; eob_at_sof2 = -1;
    frame(21, 31, 4);
    idle(13);
    send_stripe(0, 60, 4, 1'b1, 1'b1);
    for (int s = 1; s < NSTR; s++) send_stripe(s, 60 + s * 23, 4, 1'b0, 1'b1);
    wait_drain("s6_drain", 1000);
    chk("s6_words", acc_cnt, 512);
    chk("s6_sof_count", sof_cnt, 2);
    chk("s6_sof2_after_eob", eob_at_sof2, 8);
    chk("s6_no_overflow", {63'd0, err_overflow}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
